// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the two-requester FIFO write arbiter.
//   state_t       : grant state; encoding doubles as the one-hot gnt output
//   BURST_LEN_DEF : default maximum words per grant
//   CNT_W         : width of the per-requester accepted-word counters
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_t;

   localparam int BURST_LEN_DEF = 4;
   localparam int CNT_W         = 8;

endpackage

// File: rtl/fifo_wr_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value.
//   slow_clk : clock
//   reset    : asynchronous, active-high; clears the count
//   i_en     : count enable (one increment per enabled cycle)
//   o_cnt    : current count
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             slow_clk,
   input  logic             reset,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge slow_clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin write arbiter placing words from two requesters into one
// external FIFO, with bursts of at most BURST_LEN words per grant.
//   slow_clk   : clock
//   reset      : asynchronous, active-high
//   req[1:0]   : write request per requester
//   din0/din1  : write data of requester 0 / 1
//   fifo_full  : downstream FIFO full flag
//   fifo_wr_en : FIFO write enable (combinational from req/fifo_full)
//   fifo_din   : FIFO write data (0 while idle)
//   ack[1:0]   : requester n's word is written this cycle
//   gnt[1:0]   : one-hot grant state, 00 = idle
//   cnt0/cnt1  : saturating count of words accepted per requester
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant; pick a requester, round-robin on contention
// ST_GNT0 | requester 0 owns the FIFO write port
// ST_GNT1 | requester 1 owns the FIFO write port
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int BURST_LEN  = BURST_LEN_DEF
) (
   input  logic                  slow_clk,
   input  logic                  reset,
   input  logic [1:0]            req,
   input  logic [DATA_WIDTH-1:0] din0,
   input  logic [DATA_WIDTH-1:0] din1,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [DATA_WIDTH-1:0] fifo_din,
   output logic [1:0]            ack,
   output logic [1:0]            gnt,
   output logic [CNT_W-1:0]      cnt0,
   output logic [CNT_W-1:0]      cnt1
);

   localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_last_srv;
   logic       w_last_nxt;
   logic [3:0] r_burst;
   logic [3:0] w_burst_nxt;

   logic       w_granted;
   logic       w_cur;
   logic       w_own_req;
   logic       w_oth_req;
   logic       w_wr_en;
   logic       w_release;

   assign w_granted = (r_state == ST_GNT0) || (r_state == ST_GNT1);
   assign w_cur     = (r_state == ST_GNT1);
   assign w_own_req = w_granted & req[w_cur];
   assign w_oth_req = w_granted & req[~w_cur];
   assign w_wr_en   = w_own_req & ~fifo_full;

   // A stalled cycle (owner still requesting, FIFO full) never releases.
   assign w_release = ~w_own_req | (w_wr_en & (r_burst == BURST_LAST));

   always_comb begin
      w_state_nxt = r_state;
      w_last_nxt  = r_last_srv;
      w_burst_nxt = r_burst;
      case (r_state)
         ST_IDLE: begin
            // r_last_srv == 1 means requester 0 wins a tie.
            if (req[0] && (!req[1] || r_last_srv)) begin
               w_state_nxt = ST_GNT0;
               w_last_nxt  = 1'b0;
               w_burst_nxt = 4'd0;
            end else if (req[1]) begin
               w_state_nxt = ST_GNT1;
               w_last_nxt  = 1'b1;
               w_burst_nxt = 4'd0;
            end
         end
         ST_GNT0, ST_GNT1: begin
            if (w_release) begin
               if (w_oth_req) begin
                  w_state_nxt = w_cur ? ST_GNT0 : ST_GNT1;
                  w_last_nxt  = ~w_cur;
                  w_burst_nxt = 4'd0;
               end else if (w_own_req) begin
                  // Burst exhausted but nobody else waiting: fresh burst.
                  w_state_nxt = r_state;
                  w_last_nxt  = w_cur;
                  w_burst_nxt = 4'd0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_wr_en) begin
               w_burst_nxt = r_burst + 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge slow_clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_last_srv <= 1'b1;
         r_burst    <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_srv <= w_last_nxt;
         r_burst    <= w_burst_nxt;
      end
   end

   always_comb begin
      fifo_din = '0;
      if (r_state == ST_GNT0) begin
         fifo_din = din0;
      end else if (r_state == ST_GNT1) begin
         fifo_din = din1;
      end
   end

   assign fifo_wr_en = w_wr_en;
   assign ack        = {w_wr_en & (r_state == ST_GNT1), w_wr_en & (r_state == ST_GNT0)};
   assign gnt        = r_state;

   sat_counter #(.WIDTH(CNT_W)) u_cnt0 (
      .slow_clk (slow_clk),
      .reset    (reset),
      .i_en     (ack[0]),
      .o_cnt    (cnt0)
   );

   sat_counter #(.WIDTH(CNT_W)) u_cnt1 (
      .slow_clk (slow_clk),
      .reset    (reset),
      .i_en     (ack[1]),
      .o_cnt    (cnt1)
   );

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed vector table, hand-written burst/saturation sequences and a
// randomized run compared against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int DW = 4;
   localparam int BL = 4;

   logic          slow_clk = 1'b0;
   logic          reset;
   logic [1:0]    req;
   logic [DW-1:0] din0, din1;
   logic          fifo_full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_din;
   logic [1:0]    ack, gnt;
   logic [7:0]    cnt0, cnt1;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model: owner -1 = nobody holds the port
   int m_owner, m_words, m_last;
   int m_cnt [2];

   fifo_wr_arbiter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .slow_clk   (slow_clk),
      .reset      (reset),
      .req        (req),
      .din0       (din0),
      .din1       (din1),
      .fifo_full  (fifo_full),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din),
      .ack        (ack),
      .gnt        (gnt),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   always #5 slow_clk = ~slow_clk;

   typedef struct {
      logic       rst;
      logic [1:0] rq;
      logic [3:0] d0, d1;
      logic       full;
      logic       wr;
      logic [1:0] ack, gnt;
      logic [3:0] din;
      logic [7:0] c0, c1;
   } vec_t;

   function automatic vec_t mk(logic rst, logic [1:0] rq, logic [3:0] d0, logic [3:0] d1,
                               logic full, logic wr, logic [1:0] a, logic [1:0] g,
                               logic [3:0] dn, logic [7:0] c0, logic [7:0] c1);
      vec_t v;
      v.rst = rst; v.rq = rq; v.d0 = d0; v.d1 = d1; v.full = full;
      v.wr = wr; v.ack = a; v.gnt = g; v.din = dn; v.c0 = c0; v.c1 = c1;
      return v;
   endfunction

   task automatic chk(string nm, logic [7:0] got, logic [7:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_words = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
   endtask

   task automatic model_grant(int p);
      m_owner = p; m_last = p; m_words = 0;
   endtask

   task automatic model_tick();
      logic wr;
      int   o;
      if (reset) begin
         model_reset();
         return;
      end
      if (m_owner < 0) begin
         if (req == 2'b11)      model_grant(1 - m_last);
         else if (req == 2'b01) model_grant(0);
         else if (req == 2'b10) model_grant(1);
      end else begin
         o  = m_owner;
         wr = req[o] && !fifo_full;
         if (wr) begin
            m_words++;
            if (m_cnt[o] < 255) m_cnt[o]++;
         end
         if (!req[o] || (wr && m_words == BL)) begin
            if (req[1-o])    model_grant(1 - o);
            else if (req[o]) model_grant(o);
            else             m_owner = -1;
         end
      end
   endtask

   task automatic model_check(string nm);
      logic       wr;
      logic [1:0] a, g;
      logic [3:0] dn;
      int         c0, c1;
      wr = 1'b0; a = 2'b00; g = 2'b00; dn = 4'h0;
      c0 = reset ? 0 : m_cnt[0];
      c1 = reset ? 0 : m_cnt[1];
      if (!reset && m_owner >= 0) begin
         g  = 2'(1 << m_owner);
         dn = (m_owner == 0) ? din0 : din1;
         wr = req[m_owner] && !fifo_full;
         a  = wr ? g : 2'b00;
      end
      chk({nm, " wr_en"}, 8'(fifo_wr_en), 8'(wr));
      chk({nm, " ack"},   8'(ack), 8'(a));
      chk({nm, " gnt"},   8'(gnt), 8'(g));
      chk({nm, " din"},   8'(fifo_din), 8'(dn));
      chk({nm, " cnt0"},  cnt0, 8'(c0));
      chk({nm, " cnt1"},  cnt1, 8'(c1));
   endtask

   task automatic apply(logic rst, logic [1:0] rq, logic [3:0] d0, logic [3:0] d1, logic full);
      reset = rst; req = rq; din0 = d0; din1 = d1; fifo_full = full;
      @(negedge slow_clk);
   endtask

   task automatic adv();
      @(posedge slow_clk);
      model_tick();
      #1;
   endtask

   vec_t tbl [18];

   initial begin
      //            rst rq    d0    d1    full wr ack    gnt    din   c0 c1
      tbl[0]  = mk(1, 2'b00, 4'h0, 4'h0, 0,   0, 2'b00, 2'b00, 4'h0, 0, 0);
      tbl[1]  = mk(0, 2'b01, 4'hA, 4'h0, 0,   0, 2'b00, 2'b00, 4'h0, 0, 0);
      tbl[2]  = mk(0, 2'b01, 4'hA, 4'h0, 0,   1, 2'b01, 2'b01, 4'hA, 0, 0);
      tbl[3]  = mk(0, 2'b01, 4'hB, 4'h0, 0,   1, 2'b01, 2'b01, 4'hB, 1, 0);
      tbl[4]  = mk(0, 2'b01, 4'hB, 4'h0, 1,   0, 2'b00, 2'b01, 4'hB, 2, 0);
      tbl[5]  = mk(0, 2'b01, 4'hB, 4'h0, 1,   0, 2'b00, 2'b01, 4'hB, 2, 0);
      tbl[6]  = mk(0, 2'b01, 4'hB, 4'h0, 1,   0, 2'b00, 2'b01, 4'hB, 2, 0);
      tbl[7]  = mk(0, 2'b01, 4'hC, 4'h0, 0,   1, 2'b01, 2'b01, 4'hC, 2, 0);
      tbl[8]  = mk(0, 2'b01, 4'hD, 4'h0, 0,   1, 2'b01, 2'b01, 4'hD, 3, 0);
      tbl[9]  = mk(0, 2'b10, 4'hD, 4'h5, 0,   0, 2'b00, 2'b01, 4'hD, 4, 0);
      tbl[10] = mk(0, 2'b10, 4'hD, 4'h5, 0,   1, 2'b10, 2'b10, 4'h5, 4, 0);
      tbl[11] = mk(0, 2'b00, 4'hD, 4'h5, 0,   0, 2'b00, 2'b10, 4'h5, 4, 1);
      tbl[12] = mk(0, 2'b11, 4'h1, 4'h2, 0,   0, 2'b00, 2'b00, 4'h0, 4, 1);
      tbl[13] = mk(0, 2'b11, 4'h1, 4'h2, 0,   1, 2'b01, 2'b01, 4'h1, 4, 1);
      tbl[14] = mk(0, 2'b11, 4'h1, 4'h2, 0,   1, 2'b01, 2'b01, 4'h1, 5, 1);
      tbl[15] = mk(1, 2'b11, 4'h1, 4'h2, 0,   0, 2'b00, 2'b00, 4'h0, 0, 0);
      tbl[16] = mk(0, 2'b11, 4'h1, 4'h2, 0,   0, 2'b00, 2'b00, 4'h0, 0, 0);
      tbl[17] = mk(0, 2'b11, 4'h1, 4'h2, 0,   1, 2'b01, 2'b01, 4'h1, 0, 0);

      reset = 1'b1; req = 2'b00; din0 = '0; din1 = '0; fifo_full = 1'b0;
      model_reset();
      @(posedge slow_clk);
      #1;

      // directed table
      for (int i = 0; i < 18; i++) begin
         apply(tbl[i].rst, tbl[i].rq, tbl[i].d0, tbl[i].d1, tbl[i].full);
         chk($sformatf("row%0d wr_en", i), 8'(fifo_wr_en), 8'(tbl[i].wr));
         chk($sformatf("row%0d ack", i),   8'(ack),        8'(tbl[i].ack));
         chk($sformatf("row%0d gnt", i),   8'(gnt),        8'(tbl[i].gnt));
         chk($sformatf("row%0d din", i),   8'(fifo_din),   8'(tbl[i].din));
         chk($sformatf("row%0d cnt0", i),  cnt0,           tbl[i].c0);
         chk($sformatf("row%0d cnt1", i),  cnt1,           tbl[i].c1);
         adv();
      end

      // continuous contention: BL words to 0, BL to 1, ... with no gap
      apply(1'b1, 2'b00, 4'h3, 4'h6, 1'b0);
      adv();
      for (int k = 0; k <= 6 * BL; k++) begin
         apply(1'b0, 2'b11, 4'h3, 4'h6, 1'b0);
         if (k == 0) begin
            chk("rr idle ack", 8'(ack), 8'h00);
         end else begin
            chk($sformatf("rr k%0d ack", k), 8'(ack),
                8'((((k - 1) / BL) % 2 == 0) ? 2'b01 : 2'b10));
         end
         adv();
      end
      apply(1'b0, 2'b00, 4'h3, 4'h6, 1'b0);
      chk("rr cnt0", cnt0, 8'(3 * BL));
      chk("rr cnt1", cnt1, 8'(3 * BL));
      adv();

      // saturation: 300 back-to-back writes from requester 1
      apply(1'b1, 2'b00, 4'h0, 4'h9, 1'b0);
      adv();
      for (int k = 0; k <= 300; k++) begin
         apply(1'b0, 2'b10, 4'h0, 4'h9, 1'b0);
         if (k > 0) chk($sformatf("sat k%0d ack", k), 8'(ack), 8'h02);
         if (k == 256) chk("sat cnt1 at 255", cnt1, 8'd255);
         adv();
      end
      apply(1'b0, 2'b00, 4'h0, 4'h9, 1'b0);
      chk("sat cnt1 hold", cnt1, 8'd255);
      chk("sat cnt0", cnt0, 8'd0);
      adv();

      // randomized run against the model
      for (int k = 0; k < 3000; k++) begin
         apply($urandom_range(199) == 0, 2'($urandom_range(3)), 4'($urandom),
               4'($urandom), $urandom_range(3) == 0);
         model_check($sformatf("rnd%0d", k));
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the word width of each requester and of the FIFO write port.
REQ-002 Parameter BURST_LEN, default 4, SHALL set the maximum number of words accepted per grant (legal range 1..15).
REQ-003 slow_clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous and active-high.
REQ-005 req  input  2  SHALL carry one write request per requester (bit n = requester n).
REQ-006 din0, din1  input  DATA_WIDTH  SHALL carry the write data of requester 0 and requester 1.
REQ-007 fifo_full  input  1  SHALL be the full flag of the downstream FIFO.
REQ-008 fifo_wr_en  output  1  SHALL be the write enable to the FIFO.
REQ-009 fifo_din  output  DATA_WIDTH  SHALL be the write data to the FIFO.
REQ-010 ack  output  2  SHALL indicate that requester n's word is written this cycle.
REQ-011 gnt  output  2  SHALL be the one-hot grant state (00 = idle).
REQ-012 cnt0, cnt1  output  8  SHALL count the words accepted from each requester.

Function
REQ-013 The FSM SHALL have three states: IDLE, GNT0, GNT1.
REQ-014 A 1-bit last_srv register SHALL record the most recently granted requester.
REQ-015 In IDLE, a single active req[n] SHALL move the FSM to GNTn; both active SHALL select the requester not equal to last_srv (round-robin).
REQ-016 On entering GNTn, last_srv SHALL become n and burst_cnt SHALL clear to 0.
REQ-017 In GNTn, fifo_wr_en SHALL equal req[n] AND NOT fifo_full, combinationally (same-cycle, zero latency).
REQ-018 fifo_din SHALL equal dinN while in GNTn and SHALL be 0 in IDLE.
REQ-019 ack[n] SHALL equal fifo_wr_en AND (state == GNTn); ack SHALL never have both bits set.
REQ-020 Each write SHALL increment burst_cnt (4-bit); a cycle stalled by fifo_full SHALL not change burst_cnt or the state.
REQ-021 GNTn SHALL release when req[n] is low, or when a write occurs with burst_cnt == BURST_LEN-1.
REQ-022 On release, the FSM SHALL go directly to GNTm (m != n) if req[m] is high, otherwise to IDLE; no bubble cycle.
REQ-023 On release with only req[n] still high (burst exhausted), the FSM SHALL re-grant n with burst_cnt = 0.
REQ-024 cnt0/cnt1 SHALL increment on ack[0]/ack[1] and saturate at 255.
REQ-025 A requester SHALL hold req and din stable until acked; the arbiter SHALL not check this.

Reset
REQ-026 Reset SHALL force state = IDLE, last_srv = 1 (requester 0 wins the first contention), burst_cnt = 0, and cnt0 = cnt1 = 0.
REQ-027 Under reset, fifo_wr_en, ack, gnt and fifo_din SHALL all be 0, including when reset is asserted mid-burst; no partial write SHALL occur.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, GNT0, GNT1) and the default BURST_LEN constant.
REQ-029 The saturating 8-bit counter SHALL be a single sub-module, sat_counter, instantiated twice.
REQ-030 The block SHALL instantiate no FIFO; it connects externally to fifo_full/fifo_wr_en/fifo_din.

Verification
REQ-031 Reset release, req=01, din0=0xA, full=0 -> next cycle gnt=01; then fifo_wr_en=1, fifo_din=0xA, ack=01 each cycle; cnt0 increments.
REQ-032 req=11 continuously, BURST_LEN=4 -> exactly 4 acks to requester 0, then 4 to requester 1, alternating with no idle cycle between grants.
REQ-033 In GNT0 after 2 writes, fifo_full=1 for 3 cycles -> fifo_wr_en=0, ack=00, gnt=01 held; after full drops, 2 more writes, then release.
REQ-034 In GNT1, req=10 drops to 00 -> next state IDLE, gnt=00, fifo_din=0; a later req=11 grants requester 0 (last_srv=1).
REQ-035 Drive 300 writes from requester 1 -> cnt1 = 255 and holds; cnt0 = 0.
REQ-036 Assert reset in GNT0 with burst_cnt=2 -> gnt=00, ack=00, fifo_wr_en=0 immediately; cnt0=cnt1=0.
